sram_rw_arbiter: RTL and testbench

Shares one single-port read/write SRAM macro (512 x 64, byte write mask, 1-cycle registered read) between two requesters, such as a cache refill path and a debug/probe port. It grants at most one access per cycle using round-robin arbitration and returns read data one cycle after the grant. It can optionally zero-fill the array after reset. It sits between the requesters and the SRAM macro's RW0 port, and drives that port directly.

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_init_seq.sv | 33 +++
 rtl/sram_rw_arbiter.sv | 159 +++++++++++++++
 tb/tb_sram_rw_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the two-port SRAM arbiter.
// Optional power-up zero-fill is enabled by defining SRAM_ARB_INIT_EN.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_MASK_W = DEF_DATA_W / 8;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_MASK_W-1:0] wmask;
    logic [DEF_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_init_seq.sv
// Address sweep counter used to zero-fill the SRAM after reset.
// Only instantiated when SRAM_ARB_INIT_EN is defined.
module sram_init_seq #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_active,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_count;
  logic              w_last;

  assign w_last = (r_count == LastAddr);

  // Counter parks on the last address once the sweep completes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_active && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_addr = r_count;
  assign o_done = i_active & w_last;

endmodule

// File: rtl/sram_rw_arbiter.sv
// Round-robin arbiter sharing one single-port 1-cycle-read SRAM between two requesters.
// Define SRAM_ARB_INIT_EN to zero-fill the array after reset before accepting requests.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MASK_W = DEF_MASK_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [MASK_W-1:0] req1_wmask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,

  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,

  output logic              init_done
);

  arb_state_e r_state;
  arb_state_e w_state_next;

  logic r_ptr;
  logic r_resp_pending;
  logic r_resp_owner;
  logic r_init_done;

  logic      w_run;
  logic      w_grant0;
  logic      w_grant1;
  logic      w_grant;
  sram_req_t w_req0;
  sram_req_t w_req1;
  sram_req_t w_sel;

  logic              w_sram_en;
  logic              w_sram_wmode;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [MASK_W-1:0] w_sram_wmask;
  logic [DATA_W-1:0] w_sram_wdata;

`ifdef SRAM_ARB_INIT_EN
  localparam arb_state_e ResetState = ST_INIT;

  logic [ADDR_W-1:0] w_init_addr;
  logic              w_sweep_done;

  sram_init_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_active (r_state == ST_INIT),
    .o_addr   (w_init_addr),
    .o_done   (w_sweep_done)
  );
`else
  localparam arb_state_e ResetState = ST_RUN;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ResetState;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
`ifdef SRAM_ARB_INIT_EN
    if (r_state == ST_INIT && w_sweep_done) begin
      w_state_next = ST_RUN;
    end
`endif
  end

  // Grants are gated by reset_n so nothing is accepted while reset is held.
  assign w_run    = reset_n & (r_state == ST_RUN);
  assign w_grant0 = w_run & req0_valid & (~req1_valid | ~r_ptr);
  assign w_grant1 = w_run & req1_valid & (~req0_valid |  r_ptr);
  assign w_grant  = w_grant0 | w_grant1;

  assign w_req0 = '{write: req0_write, addr: req0_addr, wmask: req0_wmask, wdata: req0_wdata};
  assign w_req1 = '{write: req1_write, addr: req1_addr, wmask: req1_wmask, wdata: req1_wdata};
  assign w_sel  = w_grant1 ? w_req1 : w_req0;

  always_comb begin
    w_sram_en    = w_grant;
    w_sram_wmode = w_grant & w_sel.write;
    w_sram_addr  = w_sel.addr;
    w_sram_wmask = w_sram_wmode ? w_sel.wmask : '0;
    w_sram_wdata = w_sel.wdata;
`ifdef SRAM_ARB_INIT_EN
    if (reset_n && r_state == ST_INIT) begin
      w_sram_en    = 1'b1;
      w_sram_wmode = 1'b1;
      w_sram_addr  = w_init_addr;
      w_sram_wmask = '1;
      w_sram_wdata = '0;
    end
`endif
  end

  // Pointer flips to the loser after every grant; response owner tracks read grants.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr          <= 1'b0;
      r_resp_pending <= 1'b0;
      r_resp_owner   <= 1'b0;
      r_init_done    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr <= w_grant0;
      end
      r_resp_pending <= w_grant & ~w_sel.write;
      r_resp_owner   <= w_grant1;
      r_init_done    <= (r_state == ST_RUN);
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign resp0_valid = reset_n & r_resp_pending & ~r_resp_owner;
  assign resp1_valid = reset_n & r_resp_pending &  r_resp_owner;
  assign resp0_rdata = sram_rdata;
  assign resp1_rdata = sram_rdata;
  assign init_done   = reset_n & r_init_done;

  assign sram_en    = w_sram_en;
  assign sram_wmode = w_sram_wmode;
  assign sram_addr  = w_sram_addr;
  assign sram_wmask = w_sram_wmask;
  assign sram_wdata = w_sram_wdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Directed, table-driven bench for sram_rw_arbiter with a behavioural 512x64 SRAM model.
// Build with SRAM_ARB_INIT_EN defined to also exercise the zero-fill sweep.
module tb_sram_rw_arbiter;

  localparam logic [63:0] D1   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] HIGH = 64'hFFFF_FFFF_0000_0000;

  typedef struct {
    logic        v0, w0;
    logic [8:0]  a0;
    logic [7:0]  m0;
    logic [63:0] d0;
    logic        v1, w1;
    logic [8:0]  a1;
    logic [7:0]  m1;
    logic [63:0] d1;
    logic        er0, er1, ewm;
    logic [8:0]  eaddr;
    logic [7:0]  emask;
    logic        ev0, ev1;
    logic [63:0] erd;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_write;
  logic [8:0]  req0_addr;
  logic [7:0]  req0_wmask;
  logic [63:0] req0_wdata;
  logic        resp0_valid;
  logic [63:0] resp0_rdata;
  logic        req1_valid, req1_ready, req1_write;
  logic [8:0]  req1_addr;
  logic [7:0]  req1_wmask;
  logic [63:0] req1_wdata;
  logic        resp1_valid;
  logic [63:0] resp1_rdata;
  logic        sram_en, sram_wmode;
  logic [8:0]  sram_addr;
  logic [7:0]  sram_wmask;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        init_done;

  logic [63:0] mem [0:511];

  int checks = 0;
  int errors = 0;

  sram_rw_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_write  (req0_write),
    .req0_addr   (req0_addr),
    .req0_wmask  (req0_wmask),
    .req0_wdata  (req0_wdata),
    .resp0_valid (resp0_valid),
    .resp0_rdata (resp0_rdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_write  (req1_write),
    .req1_addr   (req1_addr),
    .req1_wmask  (req1_wmask),
    .req1_wdata  (req1_wdata),
    .resp1_valid (resp1_valid),
    .resp1_rdata (resp1_rdata),
    .sram_en     (sram_en),
    .sram_wmode  (sram_wmode),
    .sram_addr   (sram_addr),
    .sram_wmask  (sram_wmask),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .init_done   (init_done)
  );

  always #5 clock = ~clock;

  // Behavioural single-port macro: byte-masked write, registered read.
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int b = 0; b < 8; b++) begin
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  function automatic vec_t mk(
    input logic v0, w0, input logic [8:0] a0, input logic [7:0] m0, input logic [63:0] d0,
    input logic v1, w1, input logic [8:0] a1, input logic [7:0] m1, input logic [63:0] d1,
    input logic er0, er1, ewm, input logic [8:0] eaddr, input logic [7:0] emask,
    input logic ev0, ev1, input logic [63:0] erd);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.m0 = m0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.m1 = m1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1; v.ewm = ewm; v.eaddr = eaddr; v.emask = emask;
    v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid = v.v0; req0_write = v.w0; req0_addr = v.a0; req0_wmask = v.m0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_write = v.w1; req1_addr = v.a1; req1_wmask = v.m1; req1_wdata = v.d1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ready0"}, 64'(req0_ready), 64'd0);
    checkOutput({tag, "_ready1"}, 64'(req1_ready), 64'd0);
    checkOutput({tag, "_resp0"}, 64'(resp0_valid), 64'd0);
    checkOutput({tag, "_resp1"}, 64'(resp1_valid), 64'd0);
    checkOutput({tag, "_en"}, 64'(sram_en), 64'd0);
    checkOutput({tag, "_wmode"}, 64'(sram_wmode), 64'd0);
    checkOutput({tag, "_init_done"}, 64'(init_done), 64'd0);
  endtask

  // Called at the negedge reset_n is released, with both requesters asking for reads.
  task automatic doSweep();
`ifdef SRAM_ARB_INIT_EN
    for (int i = 0; i < 512; i++) begin
      #2;
      if (req0_ready || req1_ready || !sram_en || !sram_wmode || sram_addr !== 9'(i) ||
          sram_wmask !== 8'hFF || sram_wdata !== 64'd0 || init_done) begin
        errors++;
        $display("[TB] FAIL sweep_%0d actual en=%b wm=%b addr=%0d mask=%h rdy=%b%b done=%b required en=1 wm=1 addr=%0d mask=ff rdy=00 done=0",
                 i, sram_en, sram_wmode, sram_addr, sram_wmask, req0_ready, req1_ready, init_done, i);
      end
      checks++;
      @(negedge clock);
    end
`endif
  endtask

  task automatic postReset(input string tag, input logic chkData, input logic [63:0] expData);
    doSweep();
    #2;
    checkOutput({tag, "_tie_ready0"}, 64'(req0_ready), 64'd1);
    checkOutput({tag, "_tie_ready1"}, 64'(req1_ready), 64'd0);
    checkOutput({tag, "_init_done_low"}, 64'(init_done), 64'd0);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #2;
    checkOutput({tag, "_init_done_high"}, 64'(init_done), 64'd1);
    checkOutput({tag, "_resp0"}, 64'(resp0_valid), 64'd1);
    checkOutput({tag, "_resp1"}, 64'(resp1_valid), 64'd0);
    if (chkData) checkOutput({tag, "_rdata"}, resp0_rdata, expData);
    @(negedge clock);
  endtask

  vec_t vecs [20];

  initial begin
    vecs[0]  = mk(0,0,9'd0,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,0,64'd0);
    vecs[1]  = mk(1,1,9'd5,8'hFF,D1,    0,0,9'd0,8'h00,64'd0, 1,0,1,9'd5,8'hFF, 0,0,64'd0);
    vecs[2]  = mk(0,0,9'd0,8'h00,64'd0, 1,0,9'd5,8'hFF,ONES,  0,1,0,9'd5,8'h00, 0,0,64'd0);
    vecs[3]  = mk(0,0,9'd0,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,1,D1);
    vecs[4]  = mk(1,1,9'd7,8'hFF,ONES,  0,0,9'd0,8'h00,64'd0, 1,0,1,9'd7,8'hFF, 0,0,64'd0);
    vecs[5]  = mk(1,1,9'd7,8'h0F,64'd0, 0,0,9'd0,8'h00,64'd0, 1,0,1,9'd7,8'h0F, 0,0,64'd0);
    vecs[6]  = mk(1,0,9'd7,8'hFF,64'd0, 0,0,9'd0,8'h00,64'd0, 1,0,0,9'd7,8'h00, 0,0,64'd0);
    vecs[7]  = mk(0,0,9'd0,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 1,0,HIGH);
    vecs[8]  = mk(0,0,9'd0,8'h00,64'd0, 1,1,9'd3,8'hFF,64'hAA, 0,1,1,9'd3,8'hFF, 0,0,64'd0);
    // Six cycles of contention: grants alternate 0,1,0,1,0,1.
    for (int i = 9; i <= 14; i++) begin
      logic g0;
      g0 = (i % 2) == 1;
      vecs[i] = mk(1,0,9'd5,8'h00,64'd0, 1,0,9'd7,8'h00,64'd0,
                   g0, !g0, 0, g0 ? 9'd5 : 9'd7, 8'h00,
                   (i > 9) && !g0, (i > 9) && g0, g0 ? HIGH : D1);
    end
    vecs[15] = mk(0,0,9'd0,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,1,HIGH);
    vecs[16] = mk(1,0,9'd3,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 1,0,0,9'd3,8'h00, 0,0,64'd0);
    vecs[17] = mk(0,0,9'd0,8'h00,64'd0, 1,1,9'd3,8'hFF,64'h55, 0,1,1,9'd3,8'hFF, 1,0,64'hAA);
    vecs[18] = mk(1,0,9'd3,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 1,0,0,9'd3,8'h00, 0,0,64'd0);
    vecs[19] = mk(0,0,9'd0,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 1,0,64'h55);

    // Reset with both requesters pushing: nothing may be granted.
    reset_n = 1'b0;
    applyStimulus(mk(1,0,9'd5,8'h00,64'd0, 1,0,9'd7,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,0,64'd0));
    repeat (3) @(negedge clock);
    #2;
    checkResetOutputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    postReset("startup", 1'b0, 64'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("v%0d_ready0", i), 64'(req0_ready), 64'(vecs[i].er0));
      checkOutput($sformatf("v%0d_ready1", i), 64'(req1_ready), 64'(vecs[i].er1));
      checkOutput($sformatf("v%0d_en", i), 64'(sram_en), 64'(vecs[i].er0 | vecs[i].er1));
      checkOutput($sformatf("v%0d_wmode", i), 64'(sram_wmode), 64'(vecs[i].ewm));
      if (vecs[i].er0 | vecs[i].er1) begin
        checkOutput($sformatf("v%0d_addr", i), 64'(sram_addr), 64'(vecs[i].eaddr));
        checkOutput($sformatf("v%0d_wmask", i), 64'(sram_wmask), 64'(vecs[i].emask));
      end
      checkOutput($sformatf("v%0d_resp0", i), 64'(resp0_valid), 64'(vecs[i].ev0));
      checkOutput($sformatf("v%0d_resp1", i), 64'(resp1_valid), 64'(vecs[i].ev1));
      if (vecs[i].ev0) checkOutput($sformatf("v%0d_rdata0", i), resp0_rdata, vecs[i].erd);
      if (vecs[i].ev1) checkOutput($sformatf("v%0d_rdata1", i), resp1_rdata, vecs[i].erd);
      @(negedge clock);
    end

    // Reset in the cycle after a read grant: the pending response must vanish.
    applyStimulus(mk(1,0,9'd5,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,0,64'd0));
    #2;
    checkOutput("midreset_grant", 64'(req0_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b0;
    applyStimulus(mk(1,0,9'd5,8'h00,64'd0, 1,0,9'd7,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,0,64'd0));
    #2;
    checkResetOutputs("midreset_a");
    @(negedge clock);
    #2;
    checkResetOutputs("midreset_b");
    @(negedge clock);
    reset_n = 1'b1;
`ifdef SRAM_ARB_INIT_EN
    postReset("after_reset", 1'b1, 64'd0);
    applyStimulus(mk(0,0,9'd0,8'h00,64'd0, 1,0,9'd300,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,0,64'd0));
    #2;
    checkOutput("zero_read_ready", 64'(req1_ready), 64'd1);
    @(negedge clock);
    applyStimulus(mk(0,0,9'd0,8'h00,64'd0, 0,0,9'd0,8'h00,64'd0, 0,0,0,9'd0,8'h00, 0,0,64'd0));
    #2;
    checkOutput("zero_read_valid", 64'(resp1_valid), 64'd1);
    checkOutput("zero_read_data", resp1_rdata, 64'd0);
`else
    postReset("after_reset", 1'b1, D1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
